// File: rtl/ps2_pkg.sv
// Shared constants, FSM state types and the set-2 scancode to ASCII map
// used by the PS/2 typing input block.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    F_IDLE,
    F_SHIFT,
    F_CHECK
  } frame_state_t;

  typedef enum logic [1:0] {
    S_MAKE,
    S_BREAK,
    S_EXT,
    S_EXT_BREAK
  } sc_state_t;

  // Returns {valid, ascii}; only letters and space are mapped
  function automatic logic [8:0] sc_to_ascii(input logic [7:0] code);
    logic [8:0] r;
    r = 9'h000;
    case (code)
      8'h1C: r = {1'b1, 8'h41};
      8'h32: r = {1'b1, 8'h42};
      8'h21: r = {1'b1, 8'h43};
      8'h23: r = {1'b1, 8'h44};
      8'h24: r = {1'b1, 8'h45};
      8'h2B: r = {1'b1, 8'h46};
      8'h34: r = {1'b1, 8'h47};
      8'h33: r = {1'b1, 8'h48};
      8'h43: r = {1'b1, 8'h49};
      8'h3B: r = {1'b1, 8'h4A};
      8'h42: r = {1'b1, 8'h4B};
      8'h4B: r = {1'b1, 8'h4C};
      8'h3A: r = {1'b1, 8'h4D};
      8'h31: r = {1'b1, 8'h4E};
      8'h44: r = {1'b1, 8'h4F};
      8'h4D: r = {1'b1, 8'h50};
      8'h15: r = {1'b1, 8'h51};
      8'h2D: r = {1'b1, 8'h52};
      8'h1B: r = {1'b1, 8'h53};
      8'h2C: r = {1'b1, 8'h54};
      8'h3C: r = {1'b1, 8'h55};
      8'h2A: r = {1'b1, 8'h56};
      8'h1D: r = {1'b1, 8'h57};
      8'h22: r = {1'b1, 8'h58};
      8'h35: r = {1'b1, 8'h59};
      8'h1A: r = {1'b1, 8'h5A};
      8'h29: r = {1'b1, 8'h20};
      default: r = 9'h000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchronizers, clock glitch filter, 11-bit
// frame shift/check and a mid-frame watchdog.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          filt;
  logic          filt_d;
  logic [FW-1:0] filt_cnt;
  logic          fall_c;

  frame_state_t  state;
  frame_state_t  state_nx;
  logic [9:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] wd_cnt;
  logic          wd_expired_c;
  logic          frame_ok_c;
  logic          byte_valid_c;
  logic          frame_err_c;

  // Both lines idle high, so synchronizers and filter reset to 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt      <= 1'b1;
      filt_d    <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      filt_d    <= filt;
      if (clk_sync[1] == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt     <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign fall_c       = filt_d & ~filt;
  assign wd_expired_c = (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
  // Odd parity over data+parity bits, stop bit high
  assign frame_ok_c   = shreg[9] & (^shreg[8:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= F_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      F_IDLE:  if (fall_c && !data_sync[1]) state_nx = F_SHIFT;
      F_SHIFT: begin
        if (fall_c) begin
          if (bit_cnt == 4'd9) state_nx = F_CHECK;
        end else if (wd_expired_c) begin
          state_nx = F_IDLE;
        end
      end
      F_CHECK: state_nx = F_IDLE;
      default: state_nx = F_IDLE;
    endcase
  end

  always_comb begin
    byte_valid_c = 1'b0;
    frame_err_c  = 1'b0;
    case (state)
      F_IDLE:  frame_err_c = fall_c & data_sync[1];
      F_SHIFT: frame_err_c = ~fall_c & wd_expired_c;
      F_CHECK: begin
        byte_valid_c = frame_ok_c;
        frame_err_c  = ~frame_ok_c;
      end
      default: ;
    endcase
  end

  // LSB-first shift: after 10 samples shreg = {stop, parity, data[7:0]}
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      wd_cnt     <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= byte_valid_c;
      frame_err  <= frame_err_c;
      if (byte_valid_c) rx_byte <= shreg[7:0];
      if (state == F_SHIFT) begin
        if (fall_c) begin
          shreg   <= {data_sync[1], shreg[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
          wd_cnt  <= '0;
        end else begin
          wd_cnt  <= wd_cnt + TW'(1);
        end
      end else begin
        bit_cnt <= '0;
        wd_cnt  <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_typing_input.sv
// Keyboard producer for the typing game: decodes PS/2 make/break scancodes
// into uppercase ASCII, counting accepted keypresses.
module ps2_typing_input
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       clear,
  output logic [7:0] letter,
  output logic [7:0] counter,
  output logic       key_valid,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  sc_state_t  sc_state;
  sc_state_t  sc_nx;
  logic [7:0] last_make;
  logic [8:0] map_c;
  logic       accept_c;
  logic       release_c;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .FILTER_LEN    (FILTER_LEN)
  ) u_frame_rx (
    .clk       (clk),
    .rst       (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sc_state <= S_MAKE;
    else       sc_state <= sc_nx;
  end

  always_comb begin
    sc_nx = sc_state;
    if (byte_valid) begin
      case (sc_state)
        S_MAKE: begin
          if (rx_byte == SC_BREAK)    sc_nx = S_BREAK;
          else if (rx_byte == SC_EXT) sc_nx = S_EXT;
        end
        S_BREAK:     sc_nx = S_MAKE;
        S_EXT:       sc_nx = (rx_byte == SC_BREAK) ? S_EXT_BREAK : S_MAKE;
        S_EXT_BREAK: sc_nx = S_MAKE;
      endcase
    end
  end

  // A make equal to last_make is typematic repeat and is dropped
  always_comb begin
    map_c     = sc_to_ascii(rx_byte);
    accept_c  = 1'b0;
    release_c = 1'b0;
    if (byte_valid) begin
      case (sc_state)
        S_MAKE:  accept_c  = map_c[8] && (rx_byte != last_make) &&
                             (rx_byte != SC_BREAK) && (rx_byte != SC_EXT);
        S_BREAK: release_c = (rx_byte == last_make);
        default: ;
      endcase
    end
  end

  // clear wins over a same-cycle accept but leaves sc_state alone
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      letter    <= '0;
      counter   <= '0;
      key_valid <= 1'b0;
      last_make <= '0;
    end else if (clear) begin
      letter    <= '0;
      counter   <= '0;
      key_valid <= 1'b0;
      last_make <= '0;
    end else begin
      key_valid <= accept_c;
      if (accept_c) begin
        letter    <= map_c[7:0];
        last_make <= rx_byte;
        if (counter != 8'hFF) counter <= counter + 8'd1;
      end else if (release_c) begin
        last_make <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_typing_input.sv
// Self-checking bench for ps2_typing_input: drives PS/2 frames and compares
// against a byte-stream keypress model.
module tb_ps2_typing_input;
  import ps2_pkg::*;

  localparam int unsigned TO = 100;
  localparam int QTR = 3;

  logic       clk = 1'b0;
  logic       reset, ps2_clk, ps2_data, clear;
  logic [7:0] letter, counter;
  logic       key_valid, frame_err;

  int n_tests = 0, n_fail = 0;
  int kv_cnt = 0, fe_cnt = 0, kv_consec = 0;
  logic kv_prev = 1'b0;

  logic [7:0] m_letter, m_counter, m_last;
  bit         m_break, m_ext;
  int         m_kv = 0;

  logic [7:0] codes [27] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                             8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                             8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                             8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A, 8'h29};

  ps2_typing_input #(.TIMEOUT_CYCLES(TO), .FILTER_LEN(4)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .clear(clear), .letter(letter), .counter(counter),
    .key_valid(key_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      kv_prev = 1'b0;
    end else begin
      if (key_valid === 1'b1) kv_cnt++;
      if (frame_err === 1'b1) fe_cnt++;
      if (key_valid === 1'b1 && kv_prev) kv_consec++;
      kv_prev = (key_valid === 1'b1);
    end
  end

  function automatic logic [8:0] ref_ascii(input logic [7:0] b);
    for (int i = 0; i < 27; i++)
      if (codes[i] == b) return {1'b1, (i == 26) ? 8'h20 : 8'(8'h41 + i)};
    return 9'h000;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic [8:0] m;
    m = ref_ascii(b);
    if (m_ext) begin
      if (!m_break && b == 8'hF0) m_break = 1;
      else begin m_ext = 0; m_break = 0; end
    end else if (m_break) begin
      if (b == m_last) m_last = 8'h00;
      m_break = 0;
    end else if (b == 8'hF0) m_break = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (m[8] && b != m_last) begin
      m_letter = m[7:0];
      if (m_counter != 8'd255) m_counter++;
      m_last = b;
      m_kv++;
    end
  endtask

  task automatic model_clear();
    m_letter = 0; m_counter = 0; m_last = 0;
  endtask

  task automatic model_reset();
    model_clear(); m_break = 0; m_ext = 0;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      ps2_data = bits[i];
      repeat (QTR) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (2*QTR) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (QTR) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    send_bits(frame_bits(b, bad_par), 0, 11);
    ps2_data = 1'b1;
    repeat (4*QTR) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0);
    model_byte(b);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; clear = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    n_tests++; if (letter !== 8'h00) begin n_fail++; $display("FAIL reset_letter got %h exp 00", letter); end
    n_tests++; if (counter !== 8'h00) begin n_fail++; $display("FAIL reset_counter got %h exp 00", counter); end
    n_tests++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid got %b exp 0", key_valid); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
    reset = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_map();
    logic [7:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 8'(i);
      n_tests++;
      if (sc_to_ascii(c) !== ref_ascii(c)) begin
        n_fail++; $display("FAIL map code %h got %h exp %h", c, sc_to_ascii(c), ref_ascii(c));
      end
    end
  endtask

  task automatic test_key_b();
    int kv0;
    kv0 = kv_cnt;
    send_byte(8'h32);
    n_tests++; if (letter !== 8'h42) begin n_fail++; $display("FAIL key_b_letter got %h exp 42", letter); end
    n_tests++; if (counter !== 8'd1) begin n_fail++; $display("FAIL key_b_counter got %0d exp 1", counter); end
    send_byte(8'hF0);
    send_byte(8'h32);
    n_tests++; if (kv_cnt - kv0 !== 1) begin n_fail++; $display("FAIL key_b_pulses got %0d exp 1", kv_cnt - kv0); end
    n_tests++; if (counter !== 8'd1) begin n_fail++; $display("FAIL key_b_break_counter got %0d exp 1", counter); end
  endtask

  task automatic test_phrase();
    logic [7:0] ph [14] = '{8'h32, 8'h3C, 8'h29, 8'h24, 8'h31, 8'h34, 8'h43,
                            8'h31, 8'h24, 8'h24, 8'h2D, 8'h43, 8'h31, 8'h34};
    int kv0;
    pulse_clear();
    kv0 = kv_cnt;
    for (int i = 0; i < 14; i++) begin
      send_byte(ph[i]); send_byte(8'hF0); send_byte(ph[i]);
    end
    n_tests++; if (kv_cnt - kv0 !== 14) begin n_fail++; $display("FAIL phrase_pulses got %0d exp 14", kv_cnt - kv0); end
    n_tests++; if (counter !== 8'd14) begin n_fail++; $display("FAIL phrase_counter got %0d exp 14", counter); end
    n_tests++; if (letter !== 8'h47) begin n_fail++; $display("FAIL phrase_letter got %h exp 47", letter); end
    pulse_clear();
    n_tests++; if (counter !== 8'd0) begin n_fail++; $display("FAIL phrase_clear_counter got %0d exp 0", counter); end
    n_tests++; if (letter !== 8'h00) begin n_fail++; $display("FAIL phrase_clear_letter got %h exp 00", letter); end
  endtask

  task automatic test_bad_parity();
    int kv0, fe0;
    logic [7:0] c0;
    kv0 = kv_cnt; fe0 = fe_cnt; c0 = counter;
    send_frame(8'h1C, 1'b1);
    n_tests++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL parity_frame_err got %0d exp 1", fe_cnt - fe0); end
    n_tests++; if (kv_cnt !== kv0) begin n_fail++; $display("FAIL parity_key_valid got %0d exp %0d", kv_cnt, kv0); end
    n_tests++; if (counter !== c0) begin n_fail++; $display("FAIL parity_counter got %0d exp %0d", counter, c0); end
    send_byte(8'h1C);
    n_tests++; if (letter !== 8'h41) begin n_fail++; $display("FAIL parity_recover_letter got %h exp 41", letter); end
    n_tests++; if (counter !== m_counter) begin n_fail++; $display("FAIL parity_recover_counter got %0d exp %0d", counter, m_counter); end
    send_byte(8'hF0); send_byte(8'h1C);
  endtask

  task automatic test_typematic();
    logic [7:0] c0;
    logic [7:0] seq [6] = '{8'h24, 8'h24, 8'h24, 8'hF0, 8'h24, 8'h24};
    c0 = counter;
    for (int i = 0; i < 6; i++) send_byte(seq[i]);
    n_tests++; if (counter !== 8'(c0 + 8'd2)) begin n_fail++; $display("FAIL typematic_counter got %0d exp %0d", counter, c0 + 2); end
    n_tests++; if (kv_cnt !== m_kv) begin n_fail++; $display("FAIL typematic_pulses got %0d exp %0d", kv_cnt, m_kv); end
    n_tests++; if (letter !== 8'h45) begin n_fail++; $display("FAIL typematic_letter got %h exp 45", letter); end
    send_byte(8'hF0); send_byte(8'h24);
  endtask

  task automatic test_ignored();
    int kv0;
    logic [7:0] c0, l0;
    logic [7:0] seq [6] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h05};
    kv0 = kv_cnt; c0 = counter; l0 = letter;
    for (int i = 0; i < 6; i++) send_byte(seq[i]);
    n_tests++; if (kv_cnt !== kv0) begin n_fail++; $display("FAIL ignored_pulses got %0d exp %0d", kv_cnt, kv0); end
    n_tests++; if (counter !== c0) begin n_fail++; $display("FAIL ignored_counter got %0d exp %0d", counter, c0); end
    n_tests++; if (letter !== l0) begin n_fail++; $display("FAIL ignored_letter got %h exp %h", letter, l0); end
  endtask

  task automatic test_timeout();
    int kv0, fe0;
    kv0 = kv_cnt; fe0 = fe_cnt;
    send_bits(frame_bits(8'h29, 1'b0), 0, 5);
    ps2_data = 1'b1;
    repeat (TO + 50) @(negedge clk);
    n_tests++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL timeout_frame_err got %0d exp 1", fe_cnt - fe0); end
    n_tests++; if (kv_cnt !== kv0) begin n_fail++; $display("FAIL timeout_key_valid got %0d exp %0d", kv_cnt, kv0); end
    send_byte(8'h29);
    n_tests++; if (letter !== 8'h20) begin n_fail++; $display("FAIL timeout_recover_letter got %h exp 20", letter); end
    n_tests++; if (counter !== m_counter) begin n_fail++; $display("FAIL timeout_recover_counter got %0d exp %0d", counter, m_counter); end
    send_byte(8'hF0); send_byte(8'h29);
  endtask

  task automatic test_clear();
    int kv0;
    send_byte(8'h1C);
    pulse_clear();
    n_tests++; if (counter !== 8'd0 || letter !== 8'h00) begin n_fail++; $display("FAIL clear_pulse got %h/%h exp 00/00", counter, letter); end
    kv0 = kv_cnt;
    clear = 1'b1;
    send_frame(8'h2B, 1'b0);
    clear = 1'b0;
    @(negedge clk);
    n_tests++; if (kv_cnt !== kv0) begin n_fail++; $display("FAIL clear_priority_pulses got %0d exp %0d", kv_cnt, kv0); end
    n_tests++; if (counter !== 8'd0) begin n_fail++; $display("FAIL clear_priority_counter got %0d exp 0", counter); end
    send_byte(8'hF0);
    pulse_clear();
    send_byte(8'h1C);
    n_tests++; if (kv_cnt !== kv0) begin n_fail++; $display("FAIL clear_keeps_break got %0d exp %0d", kv_cnt, kv0); end
    send_byte(8'h1C);
    n_tests++; if (counter !== 8'd1 || letter !== 8'h41) begin n_fail++; $display("FAIL clear_after got %0d/%h exp 1/41", counter, letter); end
    send_byte(8'hF0); send_byte(8'h1C);
  endtask

  task automatic test_saturation();
    int kv0;
    pulse_clear();
    kv0 = kv_cnt;
    for (int i = 0; i < 255; i++) send_byte(i[0] ? 8'h32 : 8'h1C);
    n_tests++; if (counter !== 8'd255) begin n_fail++; $display("FAIL sat_counter got %0d exp 255", counter); end
    send_byte(8'h32);
    n_tests++; if (counter !== 8'd255) begin n_fail++; $display("FAIL sat_hold got %0d exp 255", counter); end
    n_tests++; if (kv_cnt - kv0 !== 256) begin n_fail++; $display("FAIL sat_pulses got %0d exp 256", kv_cnt - kv0); end
    n_tests++; if (letter !== m_letter) begin n_fail++; $display("FAIL sat_letter got %h exp %h", letter, m_letter); end
  endtask

  task automatic test_random();
    logic [7:0] b, prev;
    int sel;
    pulse_clear();
    prev = 8'h1C;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5)      b = codes[$urandom_range(0, 26)];
      else if (sel == 6) b = 8'hF0;
      else if (sel == 7) b = 8'hE0;
      else if (sel == 8) b = 8'($urandom_range(0, 255));
      else               b = prev;
      send_byte(b);
      prev = b;
      n_tests++;
      if (letter !== m_letter || counter !== m_counter || kv_cnt !== m_kv) begin
        n_fail++;
        $display("FAIL random step %0d byte %h got %h/%0d/%0d exp %h/%0d/%0d",
                 i, b, letter, counter, kv_cnt, m_letter, m_counter, m_kv);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int fe0;
    logic [10:0] bits;
    send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'h2C);
    bits = frame_bits(8'h1C, 1'b0);
    send_bits(bits, 0, 4);
    reset = 1'b1;
    @(negedge clk);
    n_tests++; if (letter !== 8'h00 || counter !== 8'h00) begin n_fail++; $display("FAIL midreset_outputs got %h/%h exp 00/00", letter, counter); end
    n_tests++; if (key_valid !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL midreset_pulses got %b/%b exp 0/0", key_valid, frame_err); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    fe0 = fe_cnt;
    send_bits(bits, 4, 11);
    ps2_data = 1'b1;
    repeat (TO + 50) @(negedge clk);
    n_tests++; if (fe_cnt - fe0 < 1) begin n_fail++; $display("FAIL midreset_abort got %0d exp >=1", fe_cnt - fe0); end
    n_tests++; if (counter !== 8'd0) begin n_fail++; $display("FAIL midreset_tail_counter got %0d exp 0", counter); end
    send_byte(8'h4D);
    n_tests++; if (letter !== 8'h50 || counter !== 8'd1) begin n_fail++; $display("FAIL midreset_recover got %h/%0d exp 50/1", letter, counter); end
  endtask

  task automatic test_pulse_shape();
    n_tests++; if (kv_consec !== 0) begin n_fail++; $display("FAIL key_valid_back_to_back got %0d exp 0", kv_consec); end
  endtask

  initial begin
    test_reset();
    test_map();
    test_key_b();
    test_phrase();
    test_bad_parity();
    test_typematic();
    test_ignored();
    test_timeout();
    test_clear();
    test_saturation();
    test_random();
    test_reset_midframe();
    test_pulse_shape();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_typing_input.md
# ps2_typing_input

Keyboard-side producer for the typing-game level displays. It receives PS/2 frames from the keyboard and decodes make/break scancodes into uppercase ASCII. For each new keypress it presents the character on `letter`, increments the typed-letter count on `counter` and pulses `key_valid`. The level display blocks consume `letter`/`counter` directly; the top level drives `clear` when a level starts.

## Interface
- `TIMEOUT_CYCLES`, default 100000: clk cycles without a ps2_clk falling edge mid-frame before the frame is aborted (1 ms at 100 MHz).
- `FILTER_LEN`, default 4: consecutive equal synchronized samples required before the filtered ps2_clk changes.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `ps2_clk` in 1: raw keyboard clock, asynchronous.
- `ps2_data` in 1: raw keyboard data, asynchronous.
- `clear` in 1: synchronous level restart; zeroes `letter`, `counter` and repeat tracking.
- `letter` out 8: ASCII of the last accepted key.
- `counter` out 8: number of keys accepted since reset/clear; saturates at 255.
- `key_valid` out 1: one-cycle pulse when `letter`/`counter` update.
- `frame_err` out 1: one-cycle pulse when a frame is discarded.

## Operation
- Input conditioning:
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer.
  - `ps2_clk` is then glitch-filtered with `FILTER_LEN`.
  - A falling edge of the filtered clock samples the synchronized data.
- Frame receiver FSM:
  - IDLE → SHIFT on the first falling edge. That bit is the start bit and must be 0; otherwise frame_err and return to IDLE.
  - SHIFT takes 8 data bits (LSB first), an odd-parity bit, then the stop bit, which must be 1.
  - After the stop bit the FSM enters CHECK for one cycle. A good frame emits byte + byte_valid; a parity or stop error emits frame_err. The FSM then returns to IDLE.
  - Watchdog: in SHIFT, `TIMEOUT_CYCLES` with no falling edge → frame_err, IDLE, partial byte discarded.
- Scancode FSM, acting on each byte_valid:
  - MAKE:
    - 0xF0 → BREAK.
    - 0xE0 → EXT.
    - A byte equal to last_make is a typematic repeat and is ignored.
    - A mapped byte: letter ← ASCII, counter ← counter+1 (held at 255), key_valid, last_make ← byte.
    - An unmapped byte is ignored.
  - BREAK: next byte ends the key. If it equals last_make, last_make ← 0x00. Go to MAKE.
  - EXT: 0xF0 → EXT_BREAK; any other byte is ignored and the FSM goes to MAKE. Extended keys are never mapped.
  - EXT_BREAK: next byte is ignored; go to MAKE.
- Map (set 2 → ASCII):
  - A 1C, B 32, C 21, D 23, E 24, F 2B, G 34, H 33, I 43, J 3B, K 42, L 4B, M 3A.
  - N 31, O 44, P 4D, Q 15, R 2D, S 1B, T 2C, U 3C, V 2A, W 1D, X 22, Y 35, Z 1A.
  - Space 29 → 0x20.
  - Output is uppercase 0x41–0x5A.
- `clear`:
  - Does not disturb either the frame receiver or the scancode FSM.
  - Takes priority over a simultaneous accepted key: that key is dropped, with no key_valid that cycle.

## Timing
- Reset values: letter 0x00, counter 0, key_valid 0, frame_err 0; both FSMs in IDLE/MAKE; last_make 0x00.
- Latency from the filtered falling edge carrying the stop bit:
  - byte_valid or frame_err 2 cycles later (CHECK state).
  - `letter`, `counter` and `key_valid` 1 cycle after byte_valid, all in the same cycle.
- `letter`/`counter` hold their values between accepts. key_valid is never high on consecutive cycles.
- Reset asserted mid-frame: everything returns to reset values immediately. The remainder of that frame then arrives outside a start condition and the watchdog aborts it with frame_err.
- Maximum PS/2 clock is 16.7 kHz, so clk must be ≥ 100× that for the filter.

## Structure
- Shared package `ps2_pkg` holds:
  - the constants SC_BREAK=8'hF0 and SC_EXT=8'hE0;
  - the frame and scancode FSM state enums;
  - function `sc_to_ascii(input [7:0]) → {valid, [7:0] ascii}`, also used by the bench.
- Sub-module `ps2_frame_rx` contains the synchronizers, filter, shift register, parity/stop check and watchdog. Its outputs are byte, byte_valid and frame_err.
- The top level contains the scancode FSM, repeat tracking and output registers.

## Test plan
- Key B: frame 0x32, then 0xF0, 0x32 → one key_valid; letter 0x42; counter 1; no pulse for the break.
- "BU ENGINEERING": make/break for 14 keys → 14 key_valid pulses, counter 14, final letter 0x47; then `clear` → counter 0, letter 0x00.
- Bad parity on 0x1C → frame_err pulse, no key_valid, counter unchanged. The next good 0x1C → letter 0x41.
- Typematic: 0x24 ×3, then F0 24, then 0x24 → counter +2 total (first and last only).
- Ignored codes: E0 75, E0 F0 75 (up arrow) and 0x05 (F1) → no key_valid, counter unchanged. Also 255 accepted keys then one more → counter stays 255, key_valid still pulses.
- Abort and recovery:
  - Send 5 bits, then idle > `TIMEOUT_CYCLES` → one frame_err; the following 0x29 frame → letter 0x20.
  - Assert reset mid-frame → outputs return to reset values.
